// File: rtl/ihex_pkg.sv
// Shared constants for the Intel HEX loader: parser states, record types, error codes, ASCII.
// Latency: n/a (constants and one pure function).
// Backpressure: n/a.
package ihex_pkg;

  // Parser state encoding
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_COUNT = 3'd1;
  localparam logic [2:0] ST_ADDR  = 3'd2;
  localparam logic [2:0] ST_TYPE  = 3'd3;
  localparam logic [2:0] ST_DATA  = 3'd4;
  localparam logic [2:0] ST_CSUM  = 3'd5;

  // Record types
  localparam logic [7:0] REC_DATA = 8'h00;
  localparam logic [7:0] REC_EOF  = 8'h01;
  localparam logic [7:0] REC_ESA  = 8'h02;
  localparam logic [7:0] REC_SSA  = 8'h03;
  localparam logic [7:0] REC_ELA  = 8'h04;
  localparam logic [7:0] REC_SLA  = 8'h05;

  // err_code values
  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_CSUM = 2'd1;
  localparam logic [1:0] ERR_CHAR = 2'd2;
  localparam logic [1:0] ERR_REC  = 2'd3;

  // ASCII constants
  localparam logic [7:0] ASC_COLON = 8'h3A;
  localparam logic [7:0] ASC_DOT   = 8'h2E;
  localparam logic [7:0] ASC_BANG  = 8'h21;
  localparam logic [7:0] ASC_CR    = 8'h0D;
  localparam logic [7:0] ASC_LF    = 8'h0A;

  // A record type is accepted if known; type 04 additionally needs exactly two data bytes.
  function automatic logic rec_type_ok(input logic [7:0] rtype, input logic [7:0] len);
    logic ok;
    ok = 1'b0;
    if (rtype == REC_DATA || rtype == REC_EOF || rtype == REC_ESA ||
        rtype == REC_SSA  || rtype == REC_SLA)
      ok = 1'b1;
    else if (rtype == REC_ELA)
      ok = (len == 8'd2);
    return ok;
  endfunction

endpackage

// File: rtl/ihex_hex_decode.sv
// ASCII hex digit decoder: '0'-'9', 'A'-'F', 'a'-'f' to a nibble plus valid flag.
// Latency: combinational.
// Backpressure: none.
module ihex_hex_decode (
  input  logic [7:0] ascii,
  output logic       valid,
  output logic [3:0] nibble
);

  // Map digit ranges; letters land on 10..15 via low nibble + 9 ('A'/'a' low nibble is 1)
  always_comb begin
    valid  = 1'b0;
    nibble = 4'h0;
    if (ascii >= 8'h30 && ascii <= 8'h39) begin
      valid  = 1'b1;
      nibble = ascii[3:0];
    end else if ((ascii >= 8'h41 && ascii <= 8'h46) ||
                 (ascii >= 8'h61 && ascii <= 8'h66)) begin
      valid  = 1'b1;
      nibble = ascii[3:0] + 4'd9;
    end
  end

endmodule

// File: rtl/ihex_loader.sv
// Intel HEX record parser turning a UART byte stream into memory byte writes; optional ack via IHEX_LOADER_ACK_EN.
// Latency: mem_we one cycle after the we_in carrying a data byte's low nibble; done/error one cycle after the deciding char.
// Backpressure: none on input (one char per we_in); ack output is a one-deep req/sendable slot, newer ack replaces pending.
module ihex_loader
  import ihex_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              we_in,
  input  logic [7:0]        data_in,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_data,
  output logic              done,
  output logic              error,
  output logic [1:0]        err_code
`ifdef IHEX_LOADER_ACK_EN
  ,
  input  logic              tx_sendable,
  output logic              tx_sendreq,
  output logic [7:0]        tx_data
`endif
);

  logic [2:0]  state;
  logic        hi_phase;   // 1 when the high nibble of the current byte is held
  logic [3:0]  hi_nib;
  logic [7:0]  len;
  logic [7:0]  cnt;
  logic [15:0] offset;
  logic [7:0]  rec_type;
  logic [7:0]  sum;
  logic [15:0] ext_tmp;    // type-04 payload, committed only on a good checksum
  logic [15:0] ext_addr;

  logic        hex_vld;
  logic [3:0]  hex_nib;

  logic        is_colon;
  logic        ev_colon;
  logic        ev_bad;
  logic        ev_byte;
  logic [7:0]  cur_byte;
  logic [7:0]  sum_nxt;
  logic        ev_badtype;
  logic        rec_end;
  logic        rec_ok;
  logic        err_hit;
  logic [1:0]  err_val;

  ihex_hex_decode u_dec (
    .ascii  (data_in),
    .valid  (hex_vld),
    .nibble (hex_nib)
  );

  // Classify the incoming character and derive per-cycle parse events
  always_comb begin
    is_colon   = (data_in == ASC_COLON);
    ev_colon   = we_in && is_colon;
    ev_bad     = we_in && !is_colon && (state != ST_IDLE) && !hex_vld;
    ev_byte    = we_in && !is_colon && (state != ST_IDLE) && hex_vld && hi_phase;
    cur_byte   = {hi_nib, hex_nib};
    sum_nxt    = sum + cur_byte;
    ev_badtype = ev_byte && (state == ST_TYPE) && !rec_type_ok(cur_byte, len);
    rec_end    = ev_byte && (state == ST_CSUM);
    rec_ok     = rec_end && (sum_nxt == 8'h00);
    err_hit    = 1'b0;
    err_val    = ERR_NONE;
    if ((ev_colon && state != ST_IDLE) || ev_bad) begin
      err_hit = 1'b1;
      err_val = ERR_CHAR;
    end else if (ev_badtype) begin
      err_hit = 1'b1;
      err_val = ERR_REC;
    end else if (rec_end && !rec_ok) begin
      err_hit = 1'b1;
      err_val = ERR_CSUM;
    end
  end

  // Record parser: nibble pairing, field capture and state sequencing
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      hi_phase <= 1'b0;
      hi_nib   <= 4'h0;
      len      <= 8'h00;
      cnt      <= 8'h00;
      offset   <= 16'h0000;
      rec_type <= 8'h00;
      sum      <= 8'h00;
      ext_tmp  <= 16'h0000;
    end else if (we_in) begin
      if (is_colon) begin
        state    <= ST_COUNT;
        hi_phase <= 1'b0;
        sum      <= 8'h00;
      end else if (state != ST_IDLE) begin
        if (!hex_vld) begin
          state <= ST_IDLE;
        end else if (!hi_phase) begin
          hi_nib   <= hex_nib;
          hi_phase <= 1'b1;
        end else begin
          hi_phase <= 1'b0;
          sum      <= sum_nxt;
          case (state)
            ST_COUNT: begin
              len   <= cur_byte;
              cnt   <= 8'h00;
              state <= ST_ADDR;
            end
            ST_ADDR: begin
              if (cnt == 8'h00) begin
                offset[15:8] <= cur_byte;
                cnt          <= 8'h01;
              end else begin
                offset[7:0] <= cur_byte;
                state       <= ST_TYPE;
              end
            end
            ST_TYPE: begin
              rec_type <= cur_byte;
              cnt      <= 8'h00;
              if (!rec_type_ok(cur_byte, len))
                state <= ST_IDLE;
              else if (len != 8'h00)
                state <= ST_DATA;
              else
                state <= ST_CSUM;
            end
            ST_DATA: begin
              if (rec_type == REC_DATA)
                offset <= offset + 16'h0001;
              if (rec_type == REC_ELA) begin
                if (cnt == 8'h00)
                  ext_tmp[15:8] <= cur_byte;
                else
                  ext_tmp[7:0] <= cur_byte;
              end
              cnt <= cnt + 8'h01;
              if (cnt == len - 8'h01)
                state <= ST_CSUM;
            end
            default: state <= ST_IDLE;
          endcase
        end
      end
    end
  end

  // Write port: data-record bytes go out immediately, before the checksum is known
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mem_we   <= 1'b0;
      mem_addr <= '0;
      mem_data <= 8'h00;
    end else begin
      mem_we <= 1'b0;
      if (ev_byte && state == ST_DATA && rec_type == REC_DATA) begin
        mem_we   <= 1'b1;
        mem_addr <= ADDR_W'({ext_addr, offset});
        mem_data <= cur_byte;
      end
    end
  end

  // Upper address: loaded from a type-04 record only when its checksum holds
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      ext_addr <= 16'h0000;
    else if (rec_ok && rec_type == REC_ELA)
      ext_addr <= ext_tmp;
  end

  // End-of-file flag: set by a good EOF record, cleared by the next ':'
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      done <= 1'b0;
    else if (ev_colon)
      done <= 1'b0;
    else if (rec_ok && rec_type == REC_EOF)
      done <= 1'b1;
  end

  // Sticky error with the first error code captured
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      error    <= 1'b0;
      err_code <= ERR_NONE;
    end else if (err_hit && !error) begin
      error    <= 1'b1;
      err_code <= err_val;
    end
  end

`ifdef IHEX_LOADER_ACK_EN
  logic rec_abort;
  assign rec_abort = (ev_colon && state != ST_IDLE) || ev_bad || ev_badtype;

  // One-deep acknowledge slot: each finished or abandoned record queues '.' or '!'
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tx_sendreq <= 1'b0;
      tx_data    <= 8'h00;
    end else if (rec_end || rec_abort) begin
      tx_sendreq <= 1'b1;
      tx_data    <= rec_ok ? ASC_DOT : ASC_BANG;
    end else if (tx_sendreq && tx_sendable) begin
      tx_sendreq <= 1'b0;
    end
  end
`else
  // No acknowledge path in this build.
`endif

endmodule

// File: tb/tb_ihex_loader.sv
module tb_ihex_loader;

  logic        clock = 1'b0;
  logic        reset;
  logic        we_in;
  logic [7:0]  data_in;

  logic        mem_we;
  logic [31:0] mem_addr;
  logic [7:0]  mem_data;
  logic        done;
  logic        error;
  logic [1:0]  err_code;

  logic        mem_we16;
  logic [15:0] mem_addr16;
  logic [7:0]  mem_data16;
  logic        done16;
  logic        error16;
  logic [1:0]  err_code16;

`ifdef IHEX_LOADER_ACK_EN
  logic        tx_sendable;
  logic        tx_sendreq;
  logic [7:0]  tx_data;
  logic        tx_sendreq16;
  logic [7:0]  tx_data16;
`endif

  always #5 clock = ~clock;

  ihex_loader #(.ADDR_W(32)) dut (
    .clock    (clock),
    .reset    (reset),
    .we_in    (we_in),
    .data_in  (data_in),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_data (mem_data),
    .done     (done),
    .error    (error),
    .err_code (err_code)
`ifdef IHEX_LOADER_ACK_EN
    ,
    .tx_sendable (tx_sendable),
    .tx_sendreq  (tx_sendreq),
    .tx_data     (tx_data)
`endif
  );

  ihex_loader #(.ADDR_W(16)) dut16 (
    .clock    (clock),
    .reset    (reset),
    .we_in    (we_in),
    .data_in  (data_in),
    .mem_we   (mem_we16),
    .mem_addr (mem_addr16),
    .mem_data (mem_data16),
    .done     (done16),
    .error    (error16),
    .err_code (err_code16)
`ifdef IHEX_LOADER_ACK_EN
    ,
    .tx_sendable (tx_sendable),
    .tx_sendreq  (tx_sendreq16),
    .tx_data     (tx_data16)
`endif
  );

  typedef struct packed {
    logic [31:0] a;
    logic [7:0]  d;
  } wr_t;

  wr_t wq[$];
  wr_t wq16[$];

  // Write monitors, sampled on the falling edge
  always @(negedge clock) begin
    if (mem_we === 1'b1)   wq.push_back({mem_addr, mem_data});
    if (mem_we16 === 1'b1) wq16.push_back({16'h0000, mem_addr16, mem_data16});
  end

  typedef struct {
    bit                rst;
    string             line;
    int                nwr;
    logic [2:0][31:0]  a;
    logic [2:0][7:0]   d;
    logic              err;
    logic [1:0]        code;
    logic              dn;
  } vec_t;

  vec_t vq[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic add(input bit rst, input string line, input int nwr,
                     input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] a2,
                     input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2,
                     input logic e, input logic [1:0] c, input logic dn);
    vec_t v;
    v.rst = rst; v.line = line; v.nwr = nwr;
    v.a[0] = a0; v.a[1] = a1; v.a[2] = a2;
    v.d[0] = d0; v.d[1] = d1; v.d[2] = d2;
    v.err = e; v.code = c; v.dn = dn;
    vq.push_back(v);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) begin
      @(negedge clock);
      we_in   = 1'b1;
      data_in = s[i];
    end
    @(negedge clock);
    we_in = 1'b0;
    @(negedge clock);
  endtask

  task automatic check_writes(input string tag, input int nwr,
                              input logic [2:0][31:0] a, input logic [2:0][7:0] d);
    logic [31:0] ea;
    chk({tag, " nwr"}, wq.size(), nwr);
    chk({tag, " nwr16"}, wq16.size(), nwr);
    for (int k = 0; k < 3; k++) begin
      if (k < nwr && k < wq.size()) begin
        chk($sformatf("%s addr%0d", tag, k), wq[k].a, a[k]);
        chk($sformatf("%s data%0d", tag, k), {24'h0, wq[k].d}, {24'h0, d[k]});
      end
      if (k < nwr && k < wq16.size()) begin
        ea = a[k] & 32'h0000FFFF;
        chk($sformatf("%s addr16_%0d", tag, k), wq16[k].a, ea);
        chk($sformatf("%s data16_%0d", tag, k), {24'h0, wq16[k].d}, {24'h0, d[k]});
      end
    end
  endtask

  task automatic check_flags(input string tag, input logic e, input logic [1:0] c, input logic dn);
    chk({tag, " error"}, {31'h0, error}, {31'h0, e});
    chk({tag, " err_code"}, {30'h0, err_code}, {30'h0, c});
    chk({tag, " done"}, {31'h0, done}, {31'h0, dn});
    chk({tag, " error16"}, {31'h0, error16}, {31'h0, e});
    chk({tag, " err_code16"}, {30'h0, err_code16}, {30'h0, c});
    chk({tag, " done16"}, {31'h0, done16}, {31'h0, dn});
  endtask

  initial begin
    logic [2:0][31:0] ha;
    logic [2:0][7:0]  hd;
    reset   = 1'b1;
    we_in   = 1'b0;
    data_in = 8'h00;
`ifdef IHEX_LOADER_ACK_EN
    tx_sendable = 1'b0;
`endif

    // Reset state
    #2 reset = 1'b0;
    #1;
    chk("rst mem_we", {31'h0, mem_we}, 32'h0);
    chk("rst mem_addr", mem_addr, 32'h0);
    chk("rst mem_data", {24'h0, mem_data}, 32'h0);
    check_flags("rst", 1'b0, 2'd0, 1'b0);
`ifdef IHEX_LOADER_ACK_EN
    chk("rst tx_sendreq", {31'h0, tx_sendreq}, 32'h0);
    chk("rst tx_data", {24'h0, tx_data}, 32'h0);
`endif
    @(negedge clock);
    reset = 1'b1;

    // Vector table (state carries over unless rst is set)
    add(1, ":0300300002337A1E", 3, 32'h30, 32'h31, 32'h32, 8'h02, 8'h33, 8'h7A, 0, 2'd0, 0);
    add(0, ":020000040001F9",   0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 0);
    add(0, ":01FFFF00AB56",     1, 32'h0001FFFF, 0, 0, 8'hAB, 0, 0, 0, 2'd0, 0);
    add(0, ":0300300002337A1F", 3, 32'h00010030, 32'h00010031, 32'h00010032,
        8'h02, 8'h33, 8'h7A, 1, 2'd1, 0);
    add(1, ":03003G",           0, 0, 0, 0, 0, 0, 0, 1, 2'd2, 0);
    add(0, ":00000001FF",       0, 0, 0, 0, 0, 0, 0, 1, 2'd2, 1);
    add(1, ":0100000600F9",     0, 0, 0, 0, 0, 0, 0, 1, 2'd3, 0);
    add(0, ":01000000ab54",     1, 32'h0, 0, 0, 8'hAB, 0, 0, 1, 2'd3, 0);
    add(1, ":030000040001FF",   0, 0, 0, 0, 0, 0, 0, 1, 2'd3, 0);
    add(1, ":0300:00000001FF",  0, 0, 0, 0, 0, 0, 0, 1, 2'd2, 1);
    add(1, "\r\n :02FFFF00AABB9B\r\n", 2, 32'h0000FFFF, 32'h0, 0, 8'hAA, 8'hBB, 0, 0, 2'd0, 0);
    add(1, ":01\n",             0, 0, 0, 0, 0, 0, 0, 1, 2'd2, 0);
    add(0, ":00000001FF",       0, 0, 0, 0, 0, 0, 0, 1, 2'd2, 1);

    for (int i = 0; i < vq.size(); i++) begin
      vec_t v;
      v = vq[i];
      if (v.rst) do_reset();
      wq.delete();
      wq16.delete();
      send_str(v.line);
      check_writes($sformatf("v%0d", i), v.nwr, v.a, v.d);
      check_flags($sformatf("v%0d", i), v.err, v.code, v.dn);
    end

    // done is cleared by the next ':' and set again by a good EOF
    do_reset();
    send_str(":00000001FF");
    chk("eof done", {31'h0, done}, 32'h1);
    send_str(":");
    chk("colon clears done", {31'h0, done}, 32'h0);
    send_str("00000001FF");
    chk("eof again done", {31'h0, done}, 32'h1);
    chk("eof again error", {31'h0, error}, 32'h0);

    // Reset in the middle of a data record
    do_reset();
    send_str(":03003G");
    wq.delete();
    wq16.delete();
    send_str(":0300300002");
    chk("mid pre write", wq.size(), 1);
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("mid rst mem_we", {31'h0, mem_we}, 32'h0);
    chk("mid rst mem_addr", mem_addr, 32'h0);
    chk("mid rst mem_data", {24'h0, mem_data}, 32'h0);
    check_flags("mid rst", 1'b0, 2'd0, 1'b0);
    @(negedge clock);
    reset = 1'b1;
    wq.delete();
    wq16.delete();
    send_str(":0300300002337A1E");
    ha[0] = 32'h30; ha[1] = 32'h31; ha[2] = 32'h32;
    hd[0] = 8'h02;  hd[1] = 8'h33;  hd[2] = 8'h7A;
    check_writes("after rst", 3, ha, hd);
    check_flags("after rst", 1'b0, 2'd0, 1'b0);

`ifdef IHEX_LOADER_ACK_EN
    // Acknowledge held while the transmitter is busy, released on first sendable
    do_reset();
    tx_sendable = 1'b0;
    send_str(":0300300002337A1E");
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      chk($sformatf("ack hold req%0d", c), {31'h0, tx_sendreq}, 32'h1);
      chk($sformatf("ack hold data%0d", c), {24'h0, tx_data}, 32'h2E);
    end
    tx_sendable = 1'b1;
    #1;
    chk("ack req at xfer", {31'h0, tx_sendreq}, 32'h1);
    @(negedge clock);
    tx_sendable = 1'b0;
    chk("ack req dropped", {31'h0, tx_sendreq}, 32'h0);
    chk("ack16 req dropped", {31'h0, tx_sendreq16}, 32'h0);
    send_str(":0300300002337A1F");
    chk("nak req", {31'h0, tx_sendreq}, 32'h1);
    chk("nak data", {24'h0, tx_data}, 32'h21);
    chk("nak16 data", {24'h0, tx_data16}, 32'h21);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ihex_loader.md
Name: ihex_loader

Overview:
- Consumes the received-byte stream of the UART receiver (one-cycle write pulse plus 8-bit byte).
- Parses ASCII Intel HEX records and issues byte writes to the target memory or FPGA register bus.
- Reports end-of-file and sticky parse errors.
- Sits directly downstream of the UART receiver and upstream of the memory write port.

Parameters:
ADDR_W, 16, width of mem_addr; the 32-bit record address {ext_addr, offset} is truncated to its low ADDR_W bits.

Ports:
clock  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
we_in  in  1  one-cycle pulse, data_in valid this cycle
data_in  in  8  received ASCII character
mem_we  out  1  one-cycle write strobe
mem_addr  out  ADDR_W  write address
mem_data  out  8  write data
done  out  1  set by a valid EOF record
error  out  1  sticky error flag
err_code  out  2  first error: 1 checksum, 2 bad character, 3 bad record type/length

Behaviour:
- Reset (reset=0, async) clears all outputs to 0, ext_addr to 0, and the state to IDLE.
- Characters are processed only in cycles with we_in=1; all other cycles hold state.
- Hex digits accepted: '0'-'9', 'A'-'F', 'a'-'f'. Two digits form a byte, high nibble first.
- States and transitions:
  - IDLE: wait for ':'; all other characters ignored. ':' clears the checksum and done, then goes to COUNT.
  - COUNT: 1 byte, length LL.
  - ADDR: 2 bytes, big-endian 16-bit offset.
  - TYPE: 1 byte. Goes to DATA if LL>0, else to CSUM.
  - DATA: LL bytes.
  - CSUM: 1 byte, then back to IDLE.
- Checksum: 8-bit running sum of every byte from LL through CC; the record is valid iff the sum is 0x00.
- Record types:
  - 00 data: each DATA byte produces mem_we=1 for exactly one cycle, in the cycle after the we_in that carries the byte's low nibble.
    - mem_addr = {ext_addr, offset} truncated to ADDR_W.
    - offset increments by 1 per byte and wraps 0xFFFF->0x0000 (ext_addr is not incremented).
    - Writes are issued before the checksum is known; a checksum failure only flags an error.
  - 01 EOF: done=1 at CSUM if the checksum is valid. done is held until the next ':' or reset.
  - 04 extended linear address: requires LL=2. The two data bytes load ext_addr[15:0] at CSUM only if the checksum is valid. No mem_we.
  - 02/03/05: checksum checked, otherwise ignored. No mem_we.
  - Any other type, or type 04 with LL!=2: err 3, abandon the record, return to IDLE.
- Errors:
  - Non-hex character inside a record: err 2, return to IDLE.
  - ':' inside a record: err 2, restart at COUNT.
  - CR, LF and space are legal only in IDLE.
  - error is sticky until reset. err_code latches the first error only; later errors are ignored.
- Parsing continues normally after an error.

Optional Feature:
- Macro IHEX_LOADER_ACK_EN.
- When defined, the block adds ports:
  - tx_sendable  in  1
  - tx_sendreq  out  1
  - tx_data  out  8
- After each completed record, one acknowledge character is queued:
  - '.' (0x2E) if the checksum is valid and no error occurred in that record.
  - '!' (0x21) otherwise.
- tx_sendreq is held at 1 until a cycle with tx_sendable=1 (transfer occurs in that cycle); tx_sendreq drops in the next cycle.
- Queue is one deep; a newer acknowledge replaces a pending one.
- Reset value of tx_sendreq and tx_data is 0.
- When the macro is undefined, the ports are absent and no acknowledge is generated.

Decomposition:
- Shared package ihex_pkg holds:
  - parser state encoding (IDLE, COUNT, ADDR, TYPE, DATA, CSUM)
  - record-type constants (00, 01, 02, 03, 04, 05)
  - err_code values
  - ASCII constants ':', '.', '!', CR, LF
- One natural sub-module, ihex_hex_decode: combinational ASCII to {valid, nibble[3:0]}.

Test Plan:
- ":0300300002337A1E" -> three mem_we pulses: addr 0x0030/0x0031/0x0032, data 0x02/0x33/0x7A; error=0.
- ":020000040001F9" then ":01FFFF00AB56" -> ext_addr=0x0001; with ADDR_W=32, one write addr 0x0001FFFF data 0xAB; no error.
- ":0300300002337A1F" -> three writes still issued; error=1, err_code=1.
- ":00000001FF" -> done=1 after the final 'F'; then ':' -> done=0.
- ":03003G" -> err_code=2, no mem_we, return to IDLE; then ":00000001FF" -> done=1, error stays 1.
- Assert reset mid-DATA of a valid record -> all outputs 0 immediately; a full record afterwards parses correctly. With IHEX_LOADER_ACK_EN and tx_sendable=0 for 10 cycles -> tx_sendreq held, tx_data=0x2E, transfer on the first cycle with tx_sendable=1.
